// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: fetch state encoding, the NOP word,
// opcode field position and the default reset PC.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_HOLD
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam int          OP_MSB           = 31;
    localparam int          OP_LSB           = 26;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register: synchronous reset, branch load, increment by 4, hold.
// Branch loads take priority over increments.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        loadBranch,
    input  logic [31:0] branchAddr,
    input  logic        incr,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4
);

    assign pcPlus4 = pc + 32'd4;

    // Branch targets are word aligned by dropping the two low address bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (loadBranch) begin
            pc <= branchAddr & ~32'h0000_0003;
        end else if (incr) begin
            pc <= pcPlus4;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem request at a time, decode-side
// stall and execute-side redirect that squashes an in-flight fetch.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic        ImemValid,
    input  logic [31:0] ImemData,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [5:0]  Op,
    output logic [31:0] PCOut,
    output logic [31:0] PCPlus4
);

    fetch_state_e state;
    fetch_state_e nextState;
    logic         squash;
    logic [31:0]  pc;
    logic [31:0]  pcPlus4;
    logic         pcLoad;
    logic         pcIncr;
    logic         capture;
    logic         dropValid;
    logic         setSquash;
    logic         clearSquash;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .loadBranch(pcLoad),
        .branchAddr(BranchTarget),
        .incr      (pcIncr),
        .pc        (pc),
        .pcPlus4   (pcPlus4)
    );

    assign ImemAddr = pc;
    assign Op       = Instr[OP_MSB:OP_LSB];

    // A redirect always wins; once a request is accepted it cannot be withdrawn,
    // so a redirect after acceptance marks the pending response for discard.
    always_comb begin
        nextState   = state;
        pcLoad      = 1'b0;
        pcIncr      = 1'b0;
        capture     = 1'b0;
        dropValid   = 1'b0;
        setSquash   = 1'b0;
        clearSquash = 1'b0;

        case (state)
            FETCH_IDLE: begin
                nextState = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (BranchTaken) begin
                    pcLoad    = 1'b1;
                    dropValid = 1'b1;
                    if (ImemReady) begin
                        setSquash = 1'b1;
                        nextState = FETCH_WAIT;
                    end
                end else if (ImemReady) begin
                    nextState = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (BranchTaken) begin
                    pcLoad    = 1'b1;
                    dropValid = 1'b1;
                    if (ImemValid) begin
                        clearSquash = 1'b1;
                        nextState   = FETCH_REQ;
                    end else begin
                        setSquash = 1'b1;
                    end
                end else if (ImemValid) begin
                    if (squash) begin
                        clearSquash = 1'b1;
                        nextState   = FETCH_REQ;
                    end else begin
                        capture   = 1'b1;
                        nextState = FETCH_HOLD;
                    end
                end
            end
            FETCH_HOLD: begin
                if (BranchTaken) begin
                    pcLoad    = 1'b1;
                    dropValid = 1'b1;
                    nextState = FETCH_REQ;
                end else if (!Stall) begin
                    pcIncr    = 1'b1;
                    dropValid = 1'b1;
                    nextState = FETCH_REQ;
                end
            end
            default: begin
                nextState = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH_IDLE;
            squash     <= 1'b0;
            ImemReq    <= 1'b0;
            InstrValid <= 1'b0;
            Instr      <= NOP_INSTR;
            PCOut      <= RESET_PC;
            PCPlus4    <= RESET_PC + 32'd4;
        end else begin
            state   <= nextState;
            ImemReq <= (nextState == FETCH_REQ);

            if (setSquash) begin
                squash <= 1'b1;
            end else if (clearSquash) begin
                squash <= 1'b0;
            end

            if (capture) begin
                InstrValid <= 1'b1;
                Instr      <= ImemData;
                PCOut      <= pc;
                PCPlus4    <= pcPlus4;
            end else if (dropValid) begin
                InstrValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed timing scenarios plus randomized memory, stall
// and redirect traffic checked against a PC-stream model of the fetch stage.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic        ImemValid;
    logic [31:0] ImemData;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [5:0]  Op;
    logic [31:0] PCOut;
    logic [31:0] PCPlus4;

    logic        resetW;
    logic        ImemReqW;
    logic [31:0] ImemAddrW;
    logic        readyW;
    logic        ImemValidW;
    logic [31:0] ImemDataW;
    logic        stallW;
    logic        branchW;
    logic [31:0] targetW;
    logic        InstrValidW;
    logic [31:0] InstrW;
    logic [5:0]  OpW;
    logic [31:0] PCOutW;
    logic [31:0] PCPlus4W;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .ImemReq     (ImemReq),
        .ImemAddr    (ImemAddr),
        .ImemReady   (ImemReady),
        .ImemValid   (ImemValid),
        .ImemData    (ImemData),
        .Stall       (Stall),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .InstrValid  (InstrValid),
        .Instr       (Instr),
        .Op          (Op),
        .PCOut       (PCOut),
        .PCPlus4     (PCPlus4)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk         (clk),
        .reset       (resetW),
        .ImemReq     (ImemReqW),
        .ImemAddr    (ImemAddrW),
        .ImemReady   (readyW),
        .ImemValid   (ImemValidW),
        .ImemData    (ImemDataW),
        .Stall       (stallW),
        .BranchTaken (branchW),
        .BranchTarget(targetW),
        .InstrValid  (InstrValidW),
        .Instr       (InstrW),
        .Op          (OpW),
        .PCOut       (PCOutW),
        .PCPlus4     (PCPlus4W)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: expected address of the next instruction handed to decode, plus
    // the single outstanding memory request.
    logic [31:0] expPc;
    bit          pending;
    int          pendDelay;
    logic [31:0] pendAddr;
    bit          branchLast;
    int          idleCycles;

    int          readyPct;
    int          stallPct;
    int          branchPct;
    int          minLat;
    int          maxLat;
    int          branchMode;
    bit          useForce;
    logic [31:0] forceTarget;

    logic [31:0] heldPc;
    logic [31:0] heldInstr;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h8C22_0004;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyReset();
        reset        = 1'b1;
        ImemReady    = 1'b0;
        ImemValid    = 1'b0;
        ImemData     = 32'h0;
        Stall        = 1'b0;
        BranchTaken  = 1'b0;
        BranchTarget = 32'h0;
        pending      = 1'b0;
        @(negedge clk);
        checkOutput("reset ImemReq", ImemReq, 1'b0);
        checkOutput("reset ImemAddr", ImemAddr, 32'h0);
        checkOutput("reset InstrValid", InstrValid, 1'b0);
        checkOutput("reset Instr", Instr, 32'h0);
        checkOutput("reset Op", Op, 6'b000000);
        checkOutput("reset PCOut", PCOut, 32'h0);
        checkOutput("reset PCPlus4", PCPlus4, 32'h4);
        reset      = 1'b0;
        expPc      = 32'h0;
        branchLast = 1'b0;
        idleCycles = 0;
    endtask

    // One cycle: check outputs against the model, then drive the inputs that
    // the next rising edge will sample and advance the model accordingly.
    task automatic applyStimulus();
        logic [31:0] w;
        logic [31:0] r;
        bit          doBranch;
        @(negedge clk);
        w = memWord(expPc);
        if (branchLast) checkOutput("valid after branch", InstrValid, 1'b0);
        checkOutput("req while outstanding", ImemReq & pending, 1'b0);
        if (ImemReq) checkOutput("imem addr", ImemAddr, expPc);
        if (InstrValid) begin
            checkOutput("instr", Instr, w);
            checkOutput("op", Op, w[31:26]);
            checkOutput("pcout", PCOut, expPc);
            checkOutput("pcplus4", PCPlus4, expPc + 32'd4);
            checkOutput("req during hold", ImemReq, 1'b0);
        end

        ImemValid = 1'b0;
        ImemData  = $urandom;
        if (pending) begin
            if (pendDelay == 0) begin
                ImemValid = 1'b1;
                ImemData  = memWord(pendAddr);
                pending   = 1'b0;
            end else begin
                pendDelay--;
            end
        end

        Stall    = ($urandom_range(99) < stallPct);
        doBranch = 1'b0;
        case (branchMode)
            1: doBranch = pending && !ImemValid;
            2: doBranch = ImemValid;
            3: begin
                doBranch = InstrValid;
                if (doBranch) Stall = 1'b1;
            end
            default: doBranch = ($urandom_range(99) < branchPct);
        endcase
        if (doBranch) branchMode = 0;

        r = $urandom;
        if ($urandom_range(3) == 0) r = {28'hFFF_FFFF, r[3:0]};
        BranchTaken  = doBranch;
        BranchTarget = useForce ? forceTarget : r;
        ImemReady    = ($urandom_range(99) < readyPct);

        if (ImemReq && ImemReady) begin
            pending   = 1'b1;
            pendAddr  = ImemAddr;
            pendDelay = $urandom_range(maxLat, minLat) - 1;
        end

        branchLast = doBranch;
        if (doBranch) begin
            expPc = BranchTarget & ~32'h3;
        end else if (InstrValid && !Stall) begin
            expPc = expPc + 32'd4;
        end

        if (doBranch || (InstrValid && !Stall)) begin
            idleCycles = 0;
        end else begin
            idleCycles++;
        end
        if (idleCycles > 200) begin
            checkOutput("progress watchdog", idleCycles, 200);
            idleCycles = 0;
        end
    endtask

    initial begin
        resetW     = 1'b1;
        readyW     = 1'b1;
        ImemValidW = 1'b0;
        ImemDataW  = 32'h0;
        stallW     = 1'b0;
        branchW    = 1'b0;
        targetW    = 32'h0;
        readyPct   = 100;
        stallPct   = 0;
        branchPct  = 0;
        minLat     = 1;
        maxLat     = 1;
        branchMode = 0;
        useForce   = 1'b0;
        forceTarget = 32'h0;

        applyReset();

        // Best-case pipeline timing from reset.
        applyStimulus();
        checkOutput("c1 ImemReq", ImemReq, 1'b1);
        checkOutput("c1 ImemAddr", ImemAddr, 32'h0);
        applyStimulus();
        checkOutput("c2 ImemReq", ImemReq, 1'b0);
        applyStimulus();
        checkOutput("c3 InstrValid", InstrValid, 1'b1);
        checkOutput("c3 Instr", Instr, 32'h8C22_0004);
        checkOutput("c3 Op", Op, 6'b100011);
        checkOutput("c3 PCOut", PCOut, 32'h0);
        checkOutput("c3 PCPlus4", PCPlus4, 32'h4);
        applyStimulus();
        checkOutput("c4 ImemReq", ImemReq, 1'b1);
        checkOutput("c4 ImemAddr", ImemAddr, 32'h4);

        // Five stalled cycles in HOLD.
        stallPct = 100;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            if (InstrValid) break;
        end
        heldPc    = PCOut;
        heldInstr = Instr;
        checkOutput("stall valid", InstrValid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkOutput("stall held valid", InstrValid, 1'b1);
            checkOutput("stall held instr", Instr, heldInstr);
            checkOutput("stall held pcout", PCOut, heldPc);
            checkOutput("stall no req", ImemReq, 1'b0);
        end
        stallPct = 0;
        readyPct = 0;
        applyStimulus();

        // Memory not ready for three REQ cycles, accepted on the fourth.
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("notready req", ImemReq, 1'b1);
            checkOutput("notready addr", ImemAddr, heldPc + 32'd4);
        end
        readyPct = 100;
        minLat   = 3;
        maxLat   = 3;
        applyStimulus();
        checkOutput("accept req", ImemReq, 1'b1);
        checkOutput("accept addr", ImemAddr, heldPc + 32'd4);

        // Redirect while waiting for memory: the pending word is squashed.
        branchMode  = 1;
        useForce    = 1'b1;
        forceTarget = 32'h0000_0043;
        applyStimulus();
        checkOutput("wait no req", ImemReq, 1'b0);
        applyStimulus();
        checkOutput("squash still waiting", ImemReq, 1'b0);
        checkOutput("squash no valid", InstrValid, 1'b0);
        minLat = 1;
        maxLat = 1;
        for (int i = 0; i < 20; i++) begin
            if (ImemReq) break;
            checkOutput("squash no valid", InstrValid, 1'b0);
            applyStimulus();
        end
        checkOutput("redirect addr", ImemAddr, 32'h0000_0040);
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            if (InstrValid) break;
        end
        checkOutput("redirect pcout", PCOut, 32'h0000_0040);
        checkOutput("redirect instr", Instr, memWord(32'h0000_0040));

        // Redirect in the same cycle the response arrives.
        branchMode  = 2;
        forceTarget = 32'h0000_0100;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            if (branchMode == 0) break;
        end
        applyStimulus();
        checkOutput("valid+branch no valid", InstrValid, 1'b0);
        checkOutput("valid+branch req", ImemReq, 1'b1);
        checkOutput("valid+branch addr", ImemAddr, 32'h0000_0100);

        // Redirect in HOLD while decode is stalling.
        branchMode  = 3;
        forceTarget = 32'h0000_0206;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            if (branchMode == 0) break;
        end
        applyStimulus();
        checkOutput("hold branch no valid", InstrValid, 1'b0);
        checkOutput("hold branch req", ImemReq, 1'b1);
        checkOutput("hold branch addr", ImemAddr, 32'h0000_0204);

        // Randomized traffic.
        useForce  = 1'b0;
        readyPct  = 70;
        stallPct  = 30;
        branchPct = 8;
        minLat    = 1;
        maxLat    = 4;
        for (int i = 0; i < 3000; i++) applyStimulus();

        // Reset while a fetch is outstanding.
        minLat = 4;
        maxLat = 4;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            if (pending) break;
        end
        applyReset();
        minLat = 1;
        maxLat = 4;
        for (int i = 0; i < 300; i++) applyStimulus();

        // PC wrap from a reset address at the top of memory.
        @(negedge clk);
        checkOutput("wrap reset pcout", PCOutW, 32'hFFFF_FFFC);
        checkOutput("wrap reset pcplus4", PCPlus4W, 32'h0);
        resetW = 1'b0;
        @(negedge clk);
        checkOutput("wrap c1 req", ImemReqW, 1'b1);
        checkOutput("wrap c1 addr", ImemAddrW, 32'hFFFF_FFFC);
        @(negedge clk);
        ImemValidW = 1'b1;
        ImemDataW  = memWord(32'hFFFF_FFFC);
        @(negedge clk);
        ImemValidW = 1'b0;
        checkOutput("wrap valid", InstrValidW, 1'b1);
        checkOutput("wrap instr", InstrW, memWord(32'hFFFF_FFFC));
        checkOutput("wrap pcout", PCOutW, 32'hFFFF_FFFC);
        checkOutput("wrap pcplus4", PCPlus4W, 32'h0);
        @(negedge clk);
        checkOutput("wrap next req", ImemReqW, 1'b1);
        checkOutput("wrap next addr", ImemAddrW, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the MIPS datapath, directly upstream of the main control decoder. Holds the program counter, issues one word request at a time to instruction memory, and presents the fetched word together with its 6-bit opcode field to the decode stage. Supports decode-side stall and execute-side branch redirect, which squashes any in-flight fetch.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset. Bits [1:0] must be 0.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ImemReq  out  1  fetch request valid
- ImemAddr  out  32  fetch byte address; always equals PC
- ImemReady  in  1  memory accepts the request this cycle when high with ImemReq
- ImemValid  in  1  response valid; exactly one response per accepted request, at least 1 cycle after acceptance
- ImemData  in  32  response word
- Stall  in  1  decode cannot consume the instruction this cycle
- BranchTaken  in  1  redirect request from execute
- BranchTarget  in  32  redirect address; bits [1:0] ignored and forced to 0
- InstrValid  out  1  Instr/Op/PCOut are valid
- Instr  out  32  fetched instruction
- Op  out  6  Instr[31:26], feeds the control decoder
- PCOut  out  32  address of Instr
- PCPlus4  out  32  PCOut + 4, mod 2^32

## Operation
- State machine: IDLE, REQ, WAIT, HOLD.
- IDLE: single cycle after reset deasserts -> REQ.
- REQ: ImemReq=1. On ImemReady -> WAIT.
- WAIT: ImemReq=0. On ImemValid: if Squash=0, register ImemData into Instr, PCOut<=PC, InstrValid<=1 -> HOLD; if Squash=1, discard the word, clear Squash -> REQ.
- HOLD: InstrValid=1. On !Stall the instruction is consumed: PC<=PC+4, InstrValid<=0 -> REQ. On Stall, all outputs hold.
- Redirect (BranchTaken=1) takes priority over every other event in every state except IDLE:
  - PC<=BranchTarget & ~3; InstrValid<=0.
  - In REQ, REQ is re-entered with the new address.
  - In HOLD, next state is REQ; Stall is ignored.
  - In WAIT with ImemValid high the same cycle, the word is discarded -> REQ.
  - In WAIT without ImemValid, Squash<=1 and the state stays WAIT.
  - ImemReq is never withdrawn in the same cycle it is accepted; a redirect during an accepted REQ goes through the Squash path.
- Arithmetic: PC and PCPlus4 wrap modulo 2^32; PC+4 at 32'hFFFF_FFFC gives 32'h0000_0000.
- Reset values: PC=RESET_PC, state=IDLE, Squash=0, ImemReq=0, InstrValid=0, Instr=32'h0 (NOP, so Op=6'b000000), PCOut=RESET_PC, PCPlus4=RESET_PC+4.
- Reset mid-fetch: any later ImemValid for the abandoned request is ignored, because the state is no longer WAIT. Memory must not return a stale response after reset; the system guarantees this.

## Timing
- Best case (ImemReady=1, ImemValid one cycle after acceptance, no Stall):
  - reset low at cycle 0; IDLE at 0
  - ImemReq at 1
  - ImemValid at 2
  - InstrValid at 3, consumed at 3
  - next ImemReq at 4
- Throughput: one instruction per 3 cycles when no stalls occur.
- Redirect visible on ImemAddr the cycle after BranchTaken when the state becomes REQ.
- All outputs are registered. Op is combinationally Instr[31:26] of the registered Instr.

## Structure
- Shared package mips_pkg:
  - fetch state enum
  - NOP_INSTR = 32'h0
  - OP_MSB = 31, OP_LSB = 26
  - RESET_PC default
- Sub-module pc_reg: 32-bit PC register with synchronous reset to RESET_PC, load-branch, increment-by-4 and hold controls, plus PC+4 output.

## Test plan
- Reset, ImemReady=1, 1-cycle memory returning 32'h8C22_0004 at address 0 -> ImemAddr=0 at cycle 1; InstrValid, Instr=32'h8C22_0004, Op=6'b100011, PCOut=0, PCPlus4=4 at cycle 3; ImemAddr=4 at cycle 4.
- Stall held 5 cycles during HOLD -> InstrValid, Instr and PCOut constant; no ImemReq; after Stall falls, next request goes to PCOut+4.
- ImemReady low for 3 cycles in REQ -> ImemReq and ImemAddr stable throughout; accepted on the 4th cycle.
- BranchTaken with BranchTarget=32'h0000_0043 while in WAIT -> pending response discarded (InstrValid stays 0); next ImemAddr=32'h0000_0040; its word is delivered with PCOut=32'h40.
- BranchTaken and ImemValid in the same WAIT cycle, and BranchTaken in HOLD with Stall=1 -> word dropped, InstrValid low next cycle, REQ to target.
- RESET_PC=32'hFFFF_FFFC, consume one instruction -> PCPlus4=0 and next ImemAddr=0. Reset asserted during WAIT -> all outputs return to reset values the next cycle.
